// File: rtl/sn76489_pkg.sv
// Shared types and constants for the SN76489AN model: bus-interface FSM
// states, channel select codes and the wait-state counter width.
package sn76489_pkg;

  // Host write-port FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    BUSY = 2'b10,
    HOLD = 2'b11
  } bus_state_t;

  // Channel codes as carried in bits 1:2 of a latch byte.
  localparam logic [1:0] CH_TONE1 = 2'b00;
  localparam logic [1:0] CH_TONE2 = 2'b01;
  localparam logic [1:0] CH_TONE3 = 2'b10;
  localparam logic [1:0] CH_NOISE = 2'b11;

  // Width of the READY wait-state tick counter.
  localparam int WAIT_CNT_W = 6;

  // A byte with its MSB (bit 0 in the chip's numbering) set is a latch byte.
  function automatic logic is_latch_byte(input logic [0:7] b);
    return b[0];
  endfunction

endpackage

// File: rtl/sn76489_bus_if.sv
// CPU-side write port of the SN76489AN model. Detects a host write on
// CE_n/WE_n, captures the byte, tracks the latched channel/register type,
// issues one clk_en-aligned write strobe to the addressed generator and
// holds READY low for the chip's wait-state period.
module sn76489_bus_if
  import sn76489_pkg::*;
#(
  parameter int WAIT_TICKS = 32
) (
  input  logic       clock_i,
  input  logic       res_n_i,
  input  logic       clk_en_i,
  input  logic       ce_n_i,
  input  logic       we_n_i,
  input  logic [0:7] d_i,
  output logic       ready_o,
  output logic [0:7] d_o,
  output logic       r2_o,
  output logic       we_tone1_o,
  output logic       we_tone2_o,
  output logic       we_tone3_o,
  output logic       we_noise_o
);

  // Counter reload: the PEND tick counts as the first of the wait ticks'
  // companions, so BUSY runs for exactly WAIT_TICKS clk_en ticks.
  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = WAIT_CNT_W'(WAIT_TICKS - 1);
  localparam logic [WAIT_CNT_W-1:0] CNT_ZERO = {WAIT_CNT_W{1'b0}};
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE  = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};

  bus_state_t            state_r;
  bus_state_t            next_state_s;
  logic [WAIT_CNT_W-1:0] cnt_r;
  logic [WAIT_CNT_W-1:0] cnt_next_s;
  logic                  bus_act_s;
  logic                  bus_act_r;
  logic                  write_start_s;
  logic                  capture_s;
  logic                  ready_r;
  logic [0:7]            d_r;
  logic [1:0]            ch_r;
  logic                  r2_r;
  logic                  strobe_s;

  assign bus_act_s     = ~ce_n_i & ~we_n_i;
  // Only a fresh rising edge of bus activity seen while idle starts a write,
  // so a strobe held across the whole access produces a single write.
  assign write_start_s = (state_r == IDLE) & bus_act_s & ~bus_act_r;

  // Next-state, counter and capture decisions for the write-port FSM.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (write_start_s) begin
          next_state_s = PEND;
          capture_s    = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      PEND: begin
        if (clk_en_i) begin
          next_state_s = BUSY;
          cnt_next_s   = CNT_LOAD;
        end else begin
          next_state_s = PEND;
        end
      end
      BUSY: begin
        if (clk_en_i) begin
          if (cnt_r == CNT_ZERO) begin
            next_state_s = HOLD;
          end else begin
            cnt_next_s = cnt_r - CNT_ONE;
          end
        end else begin
          next_state_s = BUSY;
        end
      end
      HOLD: begin
        if (!bus_act_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, counter, bus-activity history and registered READY.
  always_ff @(posedge clock_i) begin
    if (!res_n_i) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      bus_act_r <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      state_r   <= next_state_s;
      cnt_r     <= cnt_next_s;
      bus_act_r <= bus_act_s;
      // READY is high only in states that are not part of a wait period.
      ready_r   <= (next_state_s == IDLE) || (next_state_s == HOLD);
    end
  end

  // Byte capture and latch decode; data bytes keep the latched channel/r2.
  always_ff @(posedge clock_i) begin
    if (!res_n_i) begin
      d_r  <= 8'h00;
      ch_r <= CH_TONE1;
      r2_r <= 1'b0;
    end else if (capture_s) begin
      d_r <= d_i;
      if (is_latch_byte(d_i)) begin
        ch_r <= d_i[1:2];
        r2_r <= d_i[3];
      end else begin
        ch_r <= ch_r;
        r2_r <= r2_r;
      end
    end else begin
      d_r  <= d_r;
      ch_r <= ch_r;
      r2_r <= r2_r;
    end
  end

  // The strobe is gated by reset so a pending write is dropped in the very
  // cycle reset is applied, not just after it.
  assign strobe_s = (state_r == PEND) & clk_en_i & res_n_i;

  assign we_tone1_o = strobe_s & (ch_r == CH_TONE1);
  assign we_tone2_o = strobe_s & (ch_r == CH_TONE2);
  assign we_tone3_o = strobe_s & (ch_r == CH_TONE3);
  assign we_noise_o = strobe_s & (ch_r == CH_NOISE);

  assign ready_o = ready_r;
  assign d_o     = d_r;
  assign r2_o    = r2_r;

endmodule

// File: tb/tb_sn76489_bus_if.sv
// Directed self-checking bench for sn76489_bus_if (WAIT_TICKS = 32).
module tb_sn76489_bus_if;

  logic       clock_i = 1'b0;
  logic       res_n_i = 1'b0;
  logic       clk_en_i = 1'b0;
  logic       ce_n_i = 1'b1;
  logic       we_n_i = 1'b1;
  logic [0:7] d_i = 8'h00;
  logic       ready_o;
  logic [0:7] d_o;
  logic       r2_o;
  logic       we_tone1_o, we_tone2_o, we_tone3_o, we_noise_o;

  int total = 0;
  int bad   = 0;

  // sampled outputs of the current cycle
  logic       s_ready;
  logic [7:0] s_d;
  logic       s_r2;
  logic [3:0] s_we;   // {tone1, tone2, tone3, noise}

  sn76489_bus_if #(.WAIT_TICKS(32)) dut (
    .clock_i   (clock_i),
    .res_n_i   (res_n_i),
    .clk_en_i  (clk_en_i),
    .ce_n_i    (ce_n_i),
    .we_n_i    (we_n_i),
    .d_i       (d_i),
    .ready_o   (ready_o),
    .d_o       (d_o),
    .r2_o      (r2_o),
    .we_tone1_o(we_tone1_o),
    .we_tone2_o(we_tone2_o),
    .we_tone3_o(we_tone3_o),
    .we_noise_o(we_noise_o)
  );

  always #5 clock_i = ~clock_i;

  // Apply one cycle of inputs, sample outputs at the falling edge, then
  // advance past the next rising edge.
  task automatic step(input logic act, input logic [7:0] d, input logic en, input logic rn);
    ce_n_i   = ~act;
    we_n_i   = ~act;
    d_i      = d;
    clk_en_i = en;
    res_n_i  = rn;
    @(negedge clock_i);
    s_ready = ready_o;
    s_d     = d_o;
    s_r2    = r2_o;
    s_we    = {we_tone1_o, we_tone2_o, we_tone3_o, we_noise_o};
    @(posedge clock_i);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) step(1'b1, 8'hAA, 1'b1, 1'b0);
      else       step(1'b0, 8'h00, 1'b1, 1'b1);
      total++;
      if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready cyc=%0d got=%b exp=1", i, s_ready); end
      total++;
      if (s_we !== 4'b0000) begin bad++; $display("FAIL reset_we cyc=%0d got=%b exp=0000", i, s_we); end
      total++;
      if (s_d !== 8'h00) begin bad++; $display("FAIL reset_d cyc=%0d got=%h exp=00", i, s_d); end
      total++;
      if (s_r2 !== 1'b0) begin bad++; $display("FAIL reset_r2 cyc=%0d got=%b exp=0", i, s_r2); end
    end
  endtask

  // Latch byte 0xE5 with clk_en every 4th clock. Write starts in cycle 2,
  // first clk_en after it is cycle 3; BUSY then spans 32 ticks = 128 cycles.
  task automatic test_latch_noise;
    int n_noise = 0, n_other = 0, first = -1, low = 0, low_ticks = 0;
    logic r2_at = 1'bx;
    logic [7:0] d_at = 8'hxx;
    for (int i = 0; i < 160; i++) begin
      step((i == 2) || (i == 3), 8'hE5, (i % 4) == 3, 1'b1);
      if (s_we[0]) begin
        n_noise++;
        if (first < 0) begin first = i; r2_at = s_r2; d_at = s_d; end
      end
      if (s_we[3:1] != 3'b000) n_other++;
      if (!s_ready) begin low++; if ((i % 4) == 3) low_ticks++; end
    end
    total++; if (n_noise !== 1) begin bad++; $display("FAIL noise_count got=%0d exp=1", n_noise); end
    total++; if (n_other !== 0) begin bad++; $display("FAIL noise_other got=%0d exp=0", n_other); end
    total++; if (first !== 3) begin bad++; $display("FAIL noise_cycle got=%0d exp=3", first); end
    total++; if (r2_at !== 1'b0) begin bad++; $display("FAIL noise_r2 got=%b exp=0", r2_at); end
    total++; if (d_at !== 8'hE5) begin bad++; $display("FAIL noise_d got=%h exp=e5", d_at); end
    total++; if (low_ticks !== 33) begin bad++; $display("FAIL noise_low_ticks got=%0d exp=33", low_ticks); end
    total++; if (low !== 129) begin bad++; $display("FAIL noise_low_cycles got=%0d exp=129", low); end
  endtask

  // One write with clk_en always high, then check strobe, r2 and d_o.
  task automatic single_write(input logic [7:0] b, input logic [3:0] exp_we, input logic exp_r2, input string nm);
    int n = 0, first = -1, low = 0;
    logic [3:0] we_at = 4'hx;
    logic r2_at = 1'bx;
    for (int i = 0; i < 40; i++) begin
      step(i == 0, b, 1'b1, 1'b1);
      if (s_we != 4'b0000) begin
        n++;
        if (first < 0) begin first = i; we_at = s_we; r2_at = s_r2; end
      end
      if (!s_ready) low++;
    end
    total++; if (n !== 1) begin bad++; $display("FAIL %s_count got=%0d exp=1", nm, n); end
    total++; if (we_at !== exp_we) begin bad++; $display("FAIL %s_we got=%b exp=%b", nm, we_at, exp_we); end
    total++; if (first !== 1) begin bad++; $display("FAIL %s_cycle got=%0d exp=1", nm, first); end
    total++; if (r2_at !== exp_r2) begin bad++; $display("FAIL %s_r2 got=%b exp=%b", nm, r2_at, exp_r2); end
    total++; if (s_d !== b) begin bad++; $display("FAIL %s_d got=%h exp=%h", nm, s_d, b); end
    total++; if (low !== 33) begin bad++; $display("FAIL %s_low got=%0d exp=33", nm, low); end
  endtask

  task automatic test_tone1_pair;
    single_write(8'h9A, 4'b1000, 1'b1, "latch9a");
    single_write(8'h3F, 4'b1000, 1'b1, "data3f");
  endtask

  // Bus held active 200 clocks: one strobe, 33 low cycles; release and
  // reassert gives exactly one more write.
  task automatic test_back_to_back;
    int n1 = 0, n2 = 0, low = 0;
    logic rdy33 = 1'bx, rdy34 = 1'bx;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 8'h05, 1'b1, 1'b1);
      if (s_we != 4'b0000) n1++;
      if (!s_ready) low++;
      if (i == 33) rdy33 = s_ready;
      if (i == 34) rdy34 = s_ready;
    end
    total++; if (n1 !== 1) begin bad++; $display("FAIL hold_count got=%0d exp=1", n1); end
    total++; if (low !== 33) begin bad++; $display("FAIL hold_low got=%0d exp=33", low); end
    total++; if (rdy33 !== 1'b0) begin bad++; $display("FAIL hold_rdy33 got=%b exp=0", rdy33); end
    total++; if (rdy34 !== 1'b1) begin bad++; $display("FAIL hold_rdy34 got=%b exp=1", rdy34); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL hold_rdy_end got=%b exp=1", s_ready); end
    for (int i = 0; i < 40; i++) begin
      step(i == 1, 8'h06, 1'b1, 1'b1);
      if (s_we != 4'b0000) n2++;
    end
    total++; if (n2 !== 1) begin bad++; $display("FAIL rewrite_count got=%0d exp=1", n2); end
    total++; if (s_d !== 8'h06) begin bad++; $display("FAIL rewrite_d got=%h exp=06", s_d); end
  endtask

  // Latch tone2 (0xA0), then a write of 0xC0 during BUSY must be ignored.
  task automatic test_busy_ignore;
    int n2 = 0, n3 = 0, nx = 0;
    for (int i = 0; i < 40; i++) begin
      step((i == 0) || (i == 6), (i < 3) ? 8'hA0 : 8'hC0, 1'b1, 1'b1);
      if (s_we[2]) n2++;
      if (s_we[1]) n3++;
      if (s_we[3] || s_we[0]) nx++;
    end
    total++; if (n2 !== 1) begin bad++; $display("FAIL busy_tone2 got=%0d exp=1", n2); end
    total++; if (n3 !== 0) begin bad++; $display("FAIL busy_tone3 got=%0d exp=0", n3); end
    total++; if (nx !== 0) begin bad++; $display("FAIL busy_other got=%0d exp=0", nx); end
    total++; if (s_d !== 8'hA0) begin bad++; $display("FAIL busy_d got=%h exp=a0", s_d); end
    single_write(8'h11, 4'b0100, 1'b0, "busy_data11");
  endtask

  // Latch noise (0xF0), reset for one clock in BUSY, then a data byte
  // must go to tone1 with r2=0.
  task automatic test_reset_busy;
    for (int i = 0; i < 10; i++) step(i == 0, 8'hF0, 1'b1, 1'b1);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rb_busy got=%b exp=0", s_ready); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rb_ready got=%b exp=1", s_ready); end
    total++; if (s_we !== 4'b0000) begin bad++; $display("FAIL rb_we got=%b exp=0000", s_we); end
    total++; if (s_d !== 8'h00) begin bad++; $display("FAIL rb_d got=%h exp=00", s_d); end
    total++; if (s_r2 !== 1'b0) begin bad++; $display("FAIL rb_r2 got=%b exp=0", s_r2); end
    single_write(8'h07, 4'b1000, 1'b0, "rb_data07");
  endtask

  initial begin
    test_reset;
    test_latch_noise;
    test_tone1_pair;
    test_back_to_back;
    test_busy_ignore;
    test_reset_busy;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
